wb_program_loader: RTL
======================

Name: wb_program_loader

Overview:
- Wishbone master that runs upstream of the user project wrapper's Wishbone slave port.
- Accepts a stream of 32-bit instruction words and writes them to consecutive word addresses in the core's program memory.
- Holds the HS32 core in reset while loading, then releases it.
- Replaces ad-hoc bench/firmware loading with a reusable boot-load stage.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of the first word written
MAX_WORDS, 256, largest accepted load length in words
TIMEOUT, 255, maximum number of cycles to wait for wbm_ack_i on one write before faulting

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  synchronous active-high reset
start_i  input  1  single-cycle pulse that starts a load
len_i  input  16  number of words to load, sampled when start_i is accepted
word_valid_i  input  1  word_i holds a valid word
word_i  input  32  instruction word
word_ready_o  output  1  loader accepts word_i this cycle
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable, always 1 when wbm_stb_o is 1
wbm_sel_o  output  4  byte selects
wbm_adr_o  output  32  byte address
wbm_dat_o  output  32  write data
wbm_ack_i  input  1  Wishbone acknowledge
core_rst_o  output  1  reset to the HS32 core; 1 holds the core in reset
busy_o  output  1  a load is in progress
done_o  output  1  last load completed successfully
error_o  output  1  last load was rejected or timed out
count_o  output  16  number of words acknowledged in the current or last load

Behaviour:
- Clock and reset: single clock domain on wb_clk_i. Reset is synchronous on wb_rst_i, active high.
- Reset values:
  - core_rst_o=1.
  - All other outputs 0. This includes Wishbone address and data.
  - State is IDLE.
- Reset mid-operation:
  - wb_rst_i high at any edge, including an outstanding write, drops cyc/stb at that edge.
  - The pending word is discarded.
- All outputs are registered.
- IDLE state:
  - busy_o=0 and word_ready_o=0.
  - On start_i with 1 <= len_i <= MAX_WORDS:
    - latch len_i;
    - count_o=0, done_o=0, error_o=0, core_rst_o=1, busy_o=1;
    - go to WAIT_WORD.
  - On start_i with len_i=0 or len_i>MAX_WORDS:
    - error_o=1, done_o=0, core_rst_o=1;
    - stay in IDLE.
- WAIT_WORD state:
  - word_ready_o=1.
  - On word_valid_i & word_ready_o:
    - capture word_i;
    - word_ready_o=0 at the next edge;
    - go to WRITE.
  - At that edge drive:
    - wbm_cyc_o=1, wbm_stb_o=1, wbm_we_o=1, wbm_sel_o=4'b1111;
    - wbm_adr_o = ADDR_BASE + count*4 (32-bit, wraps modulo 2^32);
    - wbm_dat_o = captured word.
- WRITE state:
  - Address, data, sel, cyc and stb are held stable until ack.
  - On wbm_ack_i, at that edge:
    - cyc/stb/we/sel drop to 0;
    - count_o increments;
    - timeout counter clears.
  - If the incremented count equals the latched length, go to DONE. Otherwise go to WAIT_WORD.
  - Minimum throughput: one word per 3 cycles when ack returns the cycle after stb.
  - Timeout: the timeout counter increments each cycle in WRITE without ack. If it reaches TIMEOUT:
    - cyc/stb drop;
    - error_o=1;
    - go to ERROR.
- DONE state:
  - Entered with done_o=1, busy_o=0.
  - core_rst_o goes to 0 one cycle after entering DONE (core released).
  - Stays in DONE until the next start_i, which is handled exactly as in IDLE. An accepted start reasserts core_rst_o=1 at the same edge.
- ERROR state:
  - busy_o=0 and error_o=1.
  - core_rst_o stays 1; the core is never released after a fault.
  - Left only by start_i, handled as in IDLE.
- start_i while busy_o=1 is ignored.
- Simultaneous wbm_ack_i and timeout expiry in the same cycle: ack wins.
- wbm_ack_i outside WRITE is ignored.
- word_valid_i outside WAIT_WORD is ignored; no word is consumed.

Test Plan:
- Basic load:
  - Stimulus: start_i with len_i=8; words 2400FF00, 24100019, 34100010, 90000003, 2450CAFE, 50000000, 2440C0DE, 5F000000 always valid; ack one cycle after stb.
  - Required response: writes to byte addresses 0x00..0x1C with the same data and sel=1111; count_o=8; done_o=1; core_rst_o falls exactly one cycle after done_o rises.
- Slow slave:
  - Stimulus: ack delayed 5 cycles.
  - Required response: adr/dat stable the whole time; one write per ack; no extra or duplicate writes.
- Timeout:
  - Stimulus: TIMEOUT=8; ack never arrives on the 3rd word.
  - Required response: cyc/stb drop after 8 cycles; error_o=1; count_o=2; core_rst_o stays 1.
- Length checks:
  - Stimulus: len_i=0, then len_i=257.
  - Required response: error_o=1 and no Wishbone activity in both cases; a following valid start_i clears error_o.
- Reset mid-write:
  - Stimulus: assert wb_rst_i while stb=1.
  - Required response: next edge gives cyc=stb=0, core_rst_o=1, count_o=0, IDLE.
- Start and stream gaps:
  - Stimulus: start_i during a 4-word load; word_valid_i gaps of 3 cycles.
  - Required response: the start is ignored, the original load completes with count_o=4, and word_ready_o is high only in WAIT_WORD.

Source files
------------

// File: rtl/wb_program_loader.sv
// wb_program_loader: Wishbone boot-load master for the HS32 core.
// Streams words into program memory, then releases core reset.
module wb_program_loader #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int          MAX_WORDS = 256,
   parameter int          TIMEOUT   = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   input  logic [15:0] len_i,
   input  logic        word_valid_i,
   input  logic [31:0] word_i,
   output logic        word_ready_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   output logic        core_rst_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [15:0] count_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_WORD,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   count_q, count_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          rdy_q, rdy_d;
   logic          cyc_q, cyc_d;
   logic          stb_q, stb_d;
   logic          we_q, we_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic          crst_q, crst_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          len_ok;
   logic [15:0]   cnt_inc;

   assign len_ok  = (len_i != 16'd0) && ({1'b0, len_i} <= MAX_LEN);
   assign cnt_inc = count_q + 16'd1;

   // Next-state and next-output decode; every output is registered.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      count_d = count_q;
      tmo_d   = tmo_q;
      rdy_d   = rdy_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      crst_d  = crst_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            // Core leaves reset one cycle after DONE is entered.
            if (state_q == S_DONE) crst_d = 1'b0;
            if (start_i && len_ok) begin
               len_d   = len_i;
               count_d = 16'd0;
               tmo_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               crst_d  = 1'b1;
               busy_d  = 1'b1;
               rdy_d   = 1'b1;
               state_d = S_WAIT_WORD;
            end else if (start_i) begin
               err_d   = 1'b1;
               done_d  = 1'b0;
               crst_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WAIT_WORD: begin
            if (word_valid_i && rdy_q) begin
               rdy_d   = 1'b0;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = 1'b1;
               sel_d   = 4'b1111;
               adr_d   = ADDR_BASE + {14'd0, count_q, 2'b00};
               dat_d   = word_i;
               tmo_d   = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            // Ack is checked first so it wins over a same-cycle timeout.
            if (wbm_ack_i) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               sel_d   = 4'b0000;
               count_d = cnt_inc;
               tmo_d   = '0;
               if (cnt_inc == len_q) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_DONE;
               end else begin
                  rdy_d   = 1'b1;
                  state_d = S_WAIT_WORD;
               end
            end else if (tmo_q == TMO_LAST) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               sel_d   = 4'b0000;
               tmo_d   = '0;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_ERROR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         len_q   <= 16'd0;
         count_q <= 16'd0;
         tmo_q   <= '0;
         rdy_q   <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 4'b0000;
         adr_q   <= 32'd0;
         dat_q   <= 32'd0;
         crst_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         count_q <= count_d;
         tmo_q   <= tmo_d;
         rdy_q   <= rdy_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         crst_q  <= crst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign word_ready_o = rdy_q;
   assign wbm_cyc_o    = cyc_q;
   assign wbm_stb_o    = stb_q;
   assign wbm_we_o     = we_q;
   assign wbm_sel_o    = sel_q;
   assign wbm_adr_o    = adr_q;
   assign wbm_dat_o    = dat_q;
   assign core_rst_o   = crst_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = err_q;
   assign count_o      = count_q;

endmodule
